pipe_stage_reg: RTL

//  Generic pipeline stage register for inter-stage latches (F->D, D->E, E->M, M->W).

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pipe_skid_entry.sv | 29 ++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: PC/instruction widths and inter-stage payload layouts.
// Stage registers size their payloads from these typedefs.
package cpu_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fd_payload_t;

  localparam int FD_PAYLOAD_W = $bits(fd_payload_t);

  // Cleared F->D latch: nop at PC 0.
  localparam fd_payload_t FD_RESET_PAYLOAD = '{pc: '0, instr: NOP_INSTR};

  function automatic fd_payload_t fd_pack(input logic [PC_W-1:0] pc,
                                          input logic [INSTR_W-1:0] instr);
    fd_payload_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data holding register with load/drop; Reset or kill returns it to RESET_VAL.
// Load wins over drop; data only moves on load so idle input X never reaches the flop.
module pipe_skid_entry #(
  parameter int             W         = 64,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         kill,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge Clk) begin
    if (Reset || kill) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline latch, 1-cycle latency, full throughput; SKID=1 adds a second entry
// so In_Ready comes from a flop, SKID=0 passes downstream ready through combinationally.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int                     PAYLOAD_W     = FD_PAYLOAD_W,
  parameter logic [PAYLOAD_W-1:0]   RESET_PAYLOAD = '0,
  parameter int                     SKID          = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [PAYLOAD_W-1:0] In_Data,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [PAYLOAD_W-1:0] Out_Data,
  output logic [1:0]           Occupancy
);

  logic                 accept;
  logic                 drain;
  logic                 main_vld;
  logic [PAYLOAD_W-1:0] main_dat;
  logic                 main_load;
  logic                 main_drop;
  logic [PAYLOAD_W-1:0] main_src;
  logic [1:0]           occ_nxt;

  assign accept    = In_Valid & In_Ready;
  assign drain     = main_vld & Out_Ready;
  assign Out_Valid = main_vld;
  assign Out_Data  = main_dat;

  pipe_skid_entry #(
    .W         (PAYLOAD_W),
    .RESET_VAL (RESET_PAYLOAD)
  ) u_main (
    .Clk       (Clk),
    .Reset     (Reset),
    .kill      (Flush),
    .load      (main_load),
    .drop      (main_drop),
    .load_data (main_src),
    .valid     (main_vld),
    .data      (main_dat)
  );

  if (SKID != 0) begin : g_skid
    logic                 skid_vld;
    logic [PAYLOAD_W-1:0] skid_dat;
    logic                 skid_load;
    logic                 skid_drop;
    logic                 main_vld_nxt;
    logic                 skid_vld_nxt;

    // skid_vld is itself a flop, so the ready path stops here.
    assign In_Ready = ~skid_vld;

    always_comb begin
      main_load = 1'b0;
      main_drop = 1'b0;
      main_src  = In_Data;
      skid_load = 1'b0;
      skid_drop = 1'b0;
      if (skid_vld) begin
        // Full: refill main from skid in order; no accept is possible here.
        if (drain) begin
          main_load = 1'b1;
          main_src  = skid_dat;
          skid_drop = 1'b1;
        end
      end else if (main_vld) begin
        if (drain && accept) begin
          main_load = 1'b1;
        end else if (drain) begin
          main_drop = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end else if (accept) begin
        main_load = 1'b1;
      end
    end

    assign main_vld_nxt = main_load | (main_vld & ~main_drop);
    assign skid_vld_nxt = skid_load | (skid_vld & ~skid_drop);
    assign occ_nxt      = {1'b0, main_vld_nxt} + {1'b0, skid_vld_nxt};

    pipe_skid_entry #(
      .W         (PAYLOAD_W),
      .RESET_VAL (RESET_PAYLOAD)
    ) u_skid (
      .Clk       (Clk),
      .Reset     (Reset),
      .kill      (Flush),
      .load      (skid_load),
      .drop      (skid_drop),
      .load_data (In_Data),
      .valid     (skid_vld),
      .data      (skid_dat)
    );
  end else begin : g_single
    logic main_vld_nxt;

    assign In_Ready = ~main_vld | Out_Ready;

    always_comb begin
      main_load = accept;
      main_drop = drain & ~accept;
      main_src  = In_Data;
    end

    assign main_vld_nxt = main_load | (main_vld & ~main_drop);
    assign occ_nxt      = {1'b0, main_vld_nxt};
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      Occupancy <= 2'd0;
    end else begin
      Occupancy <= occ_nxt;
    end
  end

endmodule
